cache_refill_ctrl: RTL and testbench
====================================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 255, SHALL set the maximum number of cycles a memory request waits for MEM_ACK before timing out (legal range 1..1023).
REQ-002 CLK  input  1  SHALL be the single clock; every flop SHALL update on its rising edge.
REQ-003 RESET  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 PC  input  32  SHALL carry the fetch address presented to the cache.
REQ-005 HitWrite  input  1  SHALL carry the cache hit/stall flag; 0 means miss.
REQ-006 FLUSH  input  1  SHALL request abort of an outstanding refill.
REQ-007 MEM_REQ  output  1  SHALL be the read request to main memory.
REQ-008 MEM_ADDR  output  32  SHALL be the word-aligned read address to main memory.
REQ-009 MEM_ACK  input  1  SHALL mark the cycle in which MEM_RDATA is valid.
REQ-010 MEM_RDATA  input  32  SHALL carry the read data from main memory.
REQ-011 Access_MM  output  1  SHALL be the refill strobe to the cache.
REQ-012 Data_MM  output  32  SHALL carry the refill word to the cache.
REQ-013 MEM_ERR  output  1  SHALL be the sticky timeout flag.
REQ-014 CNT_FILL  output  20  SHALL count completed refills.
REQ-015 CNT_STALL  output  20  SHALL count cycles spent in REQ.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, FILL, SETTLE and ERR, held in a registered state vector.
REQ-017 In IDLE with HitWrite==0, the block SHALL latch PC[31:2] and enter REQ on the next edge.
REQ-018 In REQ: MEM_REQ=1, MEM_ADDR={latched PC[31:2],2'b00}; both SHALL stay stable until MEM_ACK, FLUSH or timeout.
REQ-019 In REQ with MEM_ACK=1, the block SHALL capture MEM_RDATA into Data_MM and go to FILL; MEM_REQ SHALL be 0 from the next cycle.
REQ-020 In FILL, Access_MM SHALL be 1 for exactly one cycle, CNT_FILL SHALL increment, and the next state SHALL be SETTLE.
REQ-021 In SETTLE, HitWrite SHALL be ignored for one cycle, so the stale miss flag does not retrigger; the next state SHALL be IDLE.
REQ-022 Refill latency, first REQ cycle to Access_MM: SHALL be N+1 cycles when MEM_ACK arrives in the Nth REQ cycle (N>=1).
REQ-023 A wait counter SHALL clear on REQ entry and increment each REQ cycle without ACK; on reaching MAX_WAIT the FSM SHALL enter ERR.
REQ-024 ERR SHALL be terminal until reset: MEM_ERR=1, MEM_REQ=0, Access_MM=0.
REQ-025 FLUSH=1 in REQ SHALL return the FSM to IDLE next cycle, drop MEM_REQ, discard any same-cycle MEM_ACK data, and leave CNT_FILL unchanged (FLUSH wins over ACK).
REQ-026 FLUSH SHALL be ignored in IDLE, FILL, SETTLE and ERR.
REQ-027 CNT_STALL SHALL increment once per REQ cycle; CNT_FILL and CNT_STALL SHALL saturate at 20'hFFFFF.
REQ-028 Data_MM SHALL hold its last captured value outside FILL.
REQ-029 Access_MM and MEM_REQ SHALL never both be 1 in the same cycle.

Reset
REQ-030 RESET=0 SHALL immediately force: state=IDLE, MEM_REQ=0, MEM_ADDR=0, Access_MM=0, Data_MM=0, MEM_ERR=0, CNT_FILL=0, CNT_STALL=0, wait counter=0, latched address=0.
REQ-031 Reset asserted mid-refill SHALL abandon the request without completing it; after deassertion, the first edge SHALL evaluate IDLE normally.

Structure
REQ-032 The FSM state encoding, the 20-bit counter width and the default for MAX_WAIT SHALL live in shared package cache_pkg.
REQ-033 The timeout counter SHALL be one sub-module, refill_wait_timer, with inputs clear/enable and output expired.

Verification
REQ-034 Reset, then HitWrite=0, PC=32'h0000_0048, MEM_ACK on 3rd REQ cycle with RDATA=32'hDEAD_BEEF -> MEM_ADDR=32'h48, Access_MM pulse 4 cycles after REQ entry, Data_MM=DEAD_BEEF, CNT_FILL=1, CNT_STALL=3.
REQ-035 HitWrite held 0 through FILL and SETTLE -> exactly one refill; new REQ only if HitWrite=0 in IDLE.
REQ-036 MAX_WAIT=4, no ACK -> MEM_ERR=1 after 4 REQ cycles, MEM_REQ=0; stays until RESET.
REQ-037 FLUSH and MEM_ACK in the same REQ cycle -> IDLE next cycle, no Access_MM, CNT_FILL unchanged.
REQ-038 RESET pulsed low during REQ -> all outputs 0 asynchronously; a new miss after release refills normally.
REQ-039 Preload CNT_FILL near saturation by forcing refills -> holds at 20'hFFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg
//   Shared definitions for the instruction-cache refill controller:
//   FSM state encoding, counter widths, the MAX_WAIT default and a
//   saturating-increment helper.
package cache_pkg;

  localparam int CNT_W        = 20;   // refill / stall counter width
  localparam int WAIT_W       = 10;   // wait timer width, covers MAX_WAIT up to 1023
  localparam int MAX_WAIT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_FILL   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_ERR    = 3'd4
  } refill_state_e;

  // Increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/refill_wait_timer.sv
// refill_wait_timer
//   Counts memory-request cycles that went by without an acknowledge.
//   Ports:
//     CLK, RESET  - clock, async active-low reset
//     clear       - zero the count (held while the FSM is outside REQ)
//     enable      - one REQ cycle elapsed with no MEM_ACK
//     expired     - this enabled cycle is the MAX_WAIT-th one without ACK
module refill_wait_timer
  import cache_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WAIT_W-1:0] cnt_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      cnt_q <= '0;
    else if (clear)  cnt_q <= '0;
    else if (enable) cnt_q <= cnt_q + 1'b1;
  end

  // Combinational so the FSM leaves REQ right after the MAX_WAIT-th
  // unanswered cycle rather than one cycle later.
  assign expired = enable && (cnt_q == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
//   On a cache miss, fetches one word from main memory and strobes it
//   into the cache. Unanswered requests time out into a terminal error
//   state; FLUSH aborts an outstanding request.
//   Ports:
//     CLK, RESET          - clock, async active-low reset
//     PC, HitWrite, FLUSH - fetch address, hit flag (0 = miss), abort
//     MEM_REQ, MEM_ADDR   - word-aligned read request to memory
//     MEM_ACK, MEM_RDATA  - memory read response
//     Access_MM, Data_MM  - one-cycle refill strobe and word to the cache
//     MEM_ERR             - sticky timeout flag
//     CNT_FILL, CNT_STALL - saturating refill / REQ-cycle counters
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      PC,
  input  logic             HitWrite,
  input  logic             FLUSH,
  output logic             MEM_REQ,
  output logic [31:0]      MEM_ADDR,
  input  logic             MEM_ACK,
  input  logic [31:0]      MEM_RDATA,
  output logic             Access_MM,
  output logic [31:0]      Data_MM,
  output logic             MEM_ERR,
  output logic [CNT_W-1:0] CNT_FILL,
  output logic [CNT_W-1:0] CNT_STALL
);

  refill_state_e     state_q, state_d;
  logic [29:0]       addr_q;
  logic [31:0]       data_q;
  logic [CNT_W-1:0]  cnt_fill_q, cnt_stall_q;
  logic              in_req, wait_expired;
  logic              unused_pc_lsb;

  assign in_req        = (state_q == ST_REQ);
  assign unused_pc_lsb = ^PC[1:0];

  refill_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .CLK     (CLK),
    .RESET   (RESET),
    .clear   (!in_req),
    .enable  (in_req && !MEM_ACK),
    .expired (wait_expired)
  );

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state. In REQ, FLUSH beats ACK, and ACK beats the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (!HitWrite) state_d = ST_REQ;
      ST_REQ: begin
        if (FLUSH)             state_d = ST_IDLE;
        else if (MEM_ACK)      state_d = ST_FILL;
        else if (wait_expired) state_d = ST_ERR;
      end
      ST_FILL:   state_d = ST_SETTLE;
      // HitWrite is not looked at here: the cache has not yet lowered its
      // miss flag for the word just written.
      ST_SETTLE: state_d = ST_IDLE;
      ST_ERR:    state_d = ST_ERR;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    MEM_REQ   = 1'b0;
    Access_MM = 1'b0;
    MEM_ERR   = 1'b0;
    unique case (state_q)
      ST_REQ:  MEM_REQ   = 1'b1;
      ST_FILL: Access_MM = 1'b1;
      ST_ERR:  MEM_ERR   = 1'b1;
      default: ;
    endcase
  end

  // Datapath: address latch, refill word, counters
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr_q      <= '0;
      data_q      <= '0;
      cnt_fill_q  <= '0;
      cnt_stall_q <= '0;
    end else begin
      if (state_q == ST_IDLE && !HitWrite) addr_q <= PC[31:2];
      if (in_req && MEM_ACK && !FLUSH)     data_q <= MEM_RDATA;
      if (state_q == ST_FILL)              cnt_fill_q  <= sat_inc(cnt_fill_q);
      if (in_req)                          cnt_stall_q <= sat_inc(cnt_stall_q);
    end
  end

  assign MEM_ADDR  = {addr_q, 2'b00};
  assign Data_MM   = data_q;
  assign CNT_FILL  = cnt_fill_q;
  assign CNT_STALL = cnt_stall_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl (MAX_WAIT = 4).
module tb_cache_refill_ctrl;

  logic        CLK, RESET, HitWrite, FLUSH, MEM_ACK;
  logic [31:0] PC, MEM_RDATA, MEM_ADDR, Data_MM;
  logic        MEM_REQ, Access_MM, MEM_ERR;
  logic [19:0] CNT_FILL, CNT_STALL;

  int checks   = 0;
  int failures = 0;

  cache_refill_ctrl #(.MAX_WAIT(4)) dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .HitWrite(HitWrite), .FLUSH(FLUSH),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK),
    .MEM_RDATA(MEM_RDATA), .Access_MM(Access_MM), .Data_MM(Data_MM),
    .MEM_ERR(MEM_ERR), .CNT_FILL(CNT_FILL), .CNT_STALL(CNT_STALL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 2ns later, and check strobe exclusivity.
  task automatic tick();
    @(posedge CLK);
    #2;
    chkb("req_acc_excl", MEM_REQ & Access_MM, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chkb({tag, "_req"}, MEM_REQ, 1'b0);
    chk ({tag, "_addr"}, MEM_ADDR, 32'h0);
    chkb({tag, "_acc"}, Access_MM, 1'b0);
    chk ({tag, "_data"}, Data_MM, 32'h0);
    chkb({tag, "_err"}, MEM_ERR, 1'b0);
    chk ({tag, "_fill"}, 32'(CNT_FILL), 32'h0);
    chk ({tag, "_stall"}, 32'(CNT_STALL), 32'h0);
  endtask

  initial begin
    RESET = 1'b0; HitWrite = 1'b1; FLUSH = 1'b0; MEM_ACK = 1'b0;
    PC = 32'h0; MEM_RDATA = 32'h0;
    #12;
    chk_zero("rst");
    #1 RESET = 1'b1;
    tick();                                         // IDLE, hit

    // T1: miss at 0x48, ACK in 3rd REQ cycle
    HitWrite = 1'b0; PC = 32'h48;
    tick();                                         // REQ 1
    chkb("t1_req1", MEM_REQ, 1'b1);
    chk ("t1_addr", MEM_ADDR, 32'h48);
    chkb("t1_acc_req1", Access_MM, 1'b0);
    HitWrite = 1'b1;
    tick();                                         // REQ 2
    chkb("t1_req2", MEM_REQ, 1'b1);
    chk ("t1_addr2", MEM_ADDR, 32'h48);
    tick();                                         // REQ 3
    chkb("t1_req3", MEM_REQ, 1'b1);
    MEM_ACK = 1'b1; MEM_RDATA = 32'hDEAD_BEEF;
    tick();                                         // FILL (4th cycle)
    chkb("t1_acc", Access_MM, 1'b1);
    chkb("t1_req_fill", MEM_REQ, 1'b0);
    chk ("t1_data", Data_MM, 32'hDEAD_BEEF);
    chk ("t1_stall", 32'(CNT_STALL), 32'd3);
    MEM_ACK = 1'b0; MEM_RDATA = 32'h0;
    tick();                                         // SETTLE
    chkb("t1_acc_settle", Access_MM, 1'b0);
    chk ("t1_fill", 32'(CNT_FILL), 32'd1);
    chk ("t1_data_hold", Data_MM, 32'hDEAD_BEEF);
    tick();                                         // IDLE
    chkb("t1_idle_req", MEM_REQ, 1'b0);

    // T2: HitWrite held low through FILL/SETTLE, ACK in 1st REQ cycle
    HitWrite = 1'b0; PC = 32'h107;
    tick();                                         // REQ 1
    chk ("t2_addr", MEM_ADDR, 32'h104);
    MEM_ACK = 1'b1; MEM_RDATA = 32'h1234_5678;
    tick();                                         // FILL
    chkb("t2_acc", Access_MM, 1'b1);
    chk ("t2_data", Data_MM, 32'h1234_5678);
    MEM_ACK = 1'b0;
    tick();                                         // SETTLE, miss flag ignored
    chkb("t2_settle_req", MEM_REQ, 1'b0);
    chkb("t2_settle_acc", Access_MM, 1'b0);
    chk ("t2_fill", 32'(CNT_FILL), 32'd2);
    HitWrite = 1'b1;
    tick();                                         // IDLE
    tick();                                         // still IDLE (hit)
    chkb("t2_no_rereq", MEM_REQ, 1'b0);
    chk ("t2_stall", 32'(CNT_STALL), 32'd4);

    // T3: FLUSH ignored in IDLE and FILL; ACK on the 4th (= MAX_WAIT) cycle
    HitWrite = 1'b0; FLUSH = 1'b1; PC = 32'h300;
    tick();                                         // REQ 1
    chkb("t3_flush_idle", MEM_REQ, 1'b1);
    FLUSH = 1'b0; HitWrite = 1'b1;
    tick(); tick(); tick();                         // REQ 2..4
    chkb("t3_req4", MEM_REQ, 1'b1);
    chkb("t3_err4", MEM_ERR, 1'b0);
    MEM_ACK = 1'b1; MEM_RDATA = 32'h0BAD_F00D;
    tick();                                         // FILL
    chkb("t3_acc", Access_MM, 1'b1);
    chkb("t3_noerr", MEM_ERR, 1'b0);
    chk ("t3_data", Data_MM, 32'h0BAD_F00D);
    chk ("t3_stall", 32'(CNT_STALL), 32'd8);
    MEM_ACK = 1'b0; FLUSH = 1'b1;
    tick();                                         // SETTLE
    chk ("t3_fill", 32'(CNT_FILL), 32'd3);
    FLUSH = 1'b0;
    tick();                                         // IDLE

    // T4: FLUSH and ACK together in REQ
    HitWrite = 1'b0; PC = 32'h200;
    tick();                                         // REQ
    chkb("t4_req", MEM_REQ, 1'b1);
    HitWrite = 1'b1; FLUSH = 1'b1; MEM_ACK = 1'b1; MEM_RDATA = 32'hCAFE_F00D;
    tick();                                         // IDLE
    chkb("t4_req_drop", MEM_REQ, 1'b0);
    chkb("t4_acc", Access_MM, 1'b0);
    chk ("t4_data", Data_MM, 32'h0BAD_F00D);
    FLUSH = 1'b0; MEM_ACK = 1'b0;
    tick();
    chkb("t4_acc2", Access_MM, 1'b0);
    chk ("t4_fill", 32'(CNT_FILL), 32'd3);
    chk ("t4_stall", 32'(CNT_STALL), 32'd9);

    // T5: timeout after 4 unanswered REQ cycles, ERR terminal
    HitWrite = 1'b0; PC = 32'h400;
    tick();                                         // REQ 1
    HitWrite = 1'b1;
    tick(); tick(); tick();                         // REQ 2..4
    chkb("t5_req4", MEM_REQ, 1'b1);
    tick();                                         // ERR
    chkb("t5_err", MEM_ERR, 1'b1);
    chkb("t5_req", MEM_REQ, 1'b0);
    chk ("t5_stall", 32'(CNT_STALL), 32'd13);
    HitWrite = 1'b0; MEM_ACK = 1'b1; FLUSH = 1'b1;
    tick(); tick();
    chkb("t5_err_hold", MEM_ERR, 1'b1);
    chkb("t5_req_hold", MEM_REQ, 1'b0);
    chkb("t5_acc_hold", Access_MM, 1'b0);
    chk ("t5_fill", 32'(CNT_FILL), 32'd3);
    MEM_ACK = 1'b0; FLUSH = 1'b0; HitWrite = 1'b1;

    // T6: reset clears ERR; reset mid-REQ; then a normal refill
    #1 RESET = 1'b0;
    #1 chk_zero("t6_rst_err");
    #2 RESET = 1'b1;
    tick();
    HitWrite = 1'b0; PC = 32'h500;
    tick();                                         // REQ
    chk ("t6_addr", MEM_ADDR, 32'h500);
    HitWrite = 1'b1;
    #1 RESET = 1'b0;
    #1 chk_zero("t6_rst_req");
    #2 RESET = 1'b1;
    tick();                                         // IDLE
    chkb("t6_idle", MEM_REQ, 1'b0);
    HitWrite = 1'b0; PC = 32'h600;
    tick();                                         // REQ
    chk ("t6_addr2", MEM_ADDR, 32'h600);
    HitWrite = 1'b1; MEM_ACK = 1'b1; MEM_RDATA = 32'hA5A5_5A5A;
    tick();                                         // FILL
    chkb("t6_acc", Access_MM, 1'b1);
    chk ("t6_data", Data_MM, 32'hA5A5_5A5A);
    chk ("t6_stall", 32'(CNT_STALL), 32'd1);
    MEM_ACK = 1'b0;
    tick();                                         // SETTLE
    chk ("t6_fill", 32'(CNT_FILL), 32'd1);
    tick();                                         // IDLE

    // T7: CNT_FILL saturation
    force dut.cnt_fill_q = 20'hF_FFFE;
    tick();
    release dut.cnt_fill_q;
    chk ("t7_preload", 32'(CNT_FILL), 32'h000F_FFFE);
    for (int r = 0; r < 2; r++) begin
      HitWrite = 1'b0;
      tick();                                       // REQ
      HitWrite = 1'b1; MEM_ACK = 1'b1;
      tick();                                       // FILL
      MEM_ACK = 1'b0;
      tick();                                       // SETTLE
      chk ($sformatf("t7_sat%0d", r), 32'(CNT_FILL), 32'h000F_FFFF);
      tick();                                       // IDLE
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
